junction_phase_scheduler: RTL and testbench
===========================================

JUNCTION_PHASE_SCHEDULER -- requirements
Module: junction_phase_scheduler

Interface
REQ-001 SHALL have parameter GREEN_T, default 10, green duration in cycles (min 1).
REQ-002 SHALL have parameter YELLOW_T, default 5, yellow duration in cycles (min 1).
REQ-003 SHALL have parameter ALLRED_T, default 2, all-red clearance in cycles (min 1).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  4  level vehicle-presence request, one bit per approach 0..3.
REQ-007 SHALL have port light  output  8  2-bit light per approach, approach i at bits [2i+1:2i]; RED=00, GREEN=01, YELLOW=10; 11 never driven.
REQ-008 SHALL have port active  output  2  index of approach currently green/yellow; holds last served index otherwise.
REQ-009 SHALL have port idle  output  1  high only in IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, GREEN, YELLOW, ALLRED.
REQ-011 IDLE: all lights RED; each cycle, if req!=0, SHALL grant and enter GREEN next cycle; else stay.
REQ-012 Grant SHALL be round-robin: first set req bit scanning from (last+1) mod 4 upward with wrap; last updated to granted index.
REQ-013 GREEN SHALL last exactly GREEN_T cycles, then YELLOW exactly YELLOW_T, then ALLRED exactly ALLRED_T; requests do not shorten or extend phases.
REQ-014 On the final ALLRED cycle, SHALL sample req: nonzero -> GREEN with new grant next cycle; zero -> IDLE.
REQ-015 Only the active approach SHALL be non-RED; all others RED in every state.
REQ-016 A single persistent requester SHALL be re-granted repeatedly, with ALLRED between consecutive greens.
REQ-017 req changes during GREEN/YELLOW/ALLRED (other than final ALLRED cycle) SHALL have no effect.
REQ-018 Phase counter SHALL be sized for max(GREEN_T,YELLOW_T,ALLRED_T,WALK_T)-1, reset to 0 on every state entry, no wrap.
REQ-019 All outputs SHALL be registered; light/active/idle reflect the current state with zero combinational path from req.

Reset
REQ-020 On rst=1 at a clock edge: state=IDLE, counter=0, last=3 (so first grant scans from 0), light=8'h00, active=0, idle=1.
REQ-021 rst mid-phase SHALL abort immediately to reset values; no yellow/all-red completion.
REQ-022 In the cycle after rst deasserts, IDLE grant rules apply normally.

Configuration
REQ-023 Macro JPS_PED_WALK_EN SHALL compile in pedestrian support; absent, ports ped_req/walk and state WALK do not exist and behaviour is REQ-010..022 only.
REQ-024 With macro: input ped_req (1, single-cycle pulse), output walk (1), parameter WALK_T default 8, state WALK.
REQ-025 With macro: ped_req pulse SHALL set ped_pending in any state except WALK, where it is dropped; reset clears ped_pending.
REQ-026 With macro: in IDLE or final ALLRED cycle, ped_pending SHALL take priority over vehicle req -> WALK next cycle, clearing ped_pending.
REQ-027 With macro: WALK SHALL hold all lights RED, walk=1, idle=0 for exactly WALK_T cycles, then ALLRED; walk=0 in all other states and on reset.

Structure
REQ-028 Shared package junction_pkg SHALL hold light codes RED/GREEN/YELLOW and FSM state encoding; same light codes as the existing traffic_light block.
REQ-029 Round-robin grant logic SHALL be a sub-module jps_rr_arbiter (inputs req, last; outputs grant index, any).

Verification
REQ-030 Reset, req=0 for 20 cycles -> idle=1, light=8'h00 throughout.
REQ-031 From reset, req=4'b0101 held -> greens in order approach 0,2,0,2; each green 10 cycles, yellow 5, all-red 2; IDLE never re-entered.
REQ-032 req=4'b0010 single pulse in IDLE -> approach 1 green next cycle, full 17-cycle sequence, then IDLE (idle=1) on cycle 18.
REQ-033 rst asserted at GREEN cycle 4 -> next cycle light=8'h00, idle=1, active=0; subsequent grant starts scanning at 0.
REQ-034 (macro) ped_req pulse during approach 3 green with req=4'b1111 -> after its all-red, walk=1 for 8 cycles, then all-red 2, then approach 0 green.
REQ-035 (macro) ped_req pulse during WALK -> dropped; no second WALK follows.

Source files
------------

// File: rtl/junction_pkg.sv
// ============================================================================
//  Module      : junction_pkg
//  Description : Shared light codes, FSM state encoding and sizing helpers
//                for the junction phase scheduler.
//                Optional feature macro: JPS_PED_WALK_EN (adds ST_WALK).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package junction_pkg;

   // Light codes, identical to the traffic_light block; 2'b11 is never driven
   localparam logic [1:0] LIGHT_RED    = 2'b00;
   localparam logic [1:0] LIGHT_GREEN  = 2'b01;
   localparam logic [1:0] LIGHT_YELLOW = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GREEN  = 3'd1,
      ST_YELLOW = 3'd2,
      ST_ALLRED = 3'd3
`ifdef JPS_PED_WALK_EN
      ,ST_WALK  = 3'd4
`endif
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold values 0..max_len-1, never less than one bit
   function automatic int cnt_width(input int max_len);
      return (max_len > 1) ? $clog2(max_len) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jps_rr_arbiter.sv
// ============================================================================
//  Module      : jps_rr_arbiter
//  Description : Four-way round-robin grant. Scans from (last+1) mod 4
//                upward with wrap and returns the first requesting index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jps_rr_arbiter (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [1:0] grant,
   output logic       any
);

   logic [1:0] idx;

   // Walk from lowest to highest priority so the nearest requester wins
   always_comb begin
      grant = last;
      any   = |req;
      idx   = last;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (req[idx]) begin
            grant = idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/junction_phase_scheduler.sv
// ============================================================================
//  Module      : junction_phase_scheduler
//  Description : Four-approach junction phase scheduler. Round-robin green
//                grants with fixed green/yellow/all-red phases; all outputs
//                registered. Optional feature macro JPS_PED_WALK_EN adds a
//                pedestrian walk phase (ped_req/walk ports, WALK_T).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module junction_phase_scheduler
   import junction_pkg::*;
#(
   parameter int GREEN_T  = 10,
   parameter int YELLOW_T = 5,
   parameter int ALLRED_T = 2
`ifdef JPS_PED_WALK_EN
   ,parameter int WALK_T  = 8
`endif
) (
   input  logic       clk,
   input  logic       rst,
`ifdef JPS_PED_WALK_EN
   input  logic       ped_req,
   output logic       walk,
`endif
   input  logic [3:0] req,
   output logic [7:0] light,
   output logic [1:0] active,
   output logic       idle
);

`ifdef JPS_PED_WALK_EN
   localparam int PHASE_MAX = max2(max2(GREEN_T, YELLOW_T), max2(ALLRED_T, WALK_T));
`else
   localparam int PHASE_MAX = max2(max2(GREEN_T, YELLOW_T), ALLRED_T);
`endif
   localparam int CNT_W = cnt_width(PHASE_MAX);

   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
`ifdef JPS_PED_WALK_EN
   localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
`endif

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [1:0]       last_q,   last_d;
   logic [7:0]       light_q,  light_d;
   logic [1:0]       active_q, active_d;
   logic             idle_q,   idle_d;
`ifdef JPS_PED_WALK_EN
   logic             ped_pending_q, ped_pending_d;
   logic             walk_q,        walk_d;
`endif

   logic [1:0] grant_idx;
   logic       grant_any;

   jps_rr_arbiter u_arb (
      .req   (req),
      .last  (last_q),
      .grant (grant_idx),
      .any   (grant_any)
   );

   // Next-state, phase counter and registered-output values
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      last_d   = last_q;
      active_d = active_q;
`ifdef JPS_PED_WALK_EN
      ped_pending_d = ped_pending_q;
      if (ped_req && (state_q != ST_WALK)) begin
         ped_pending_d = 1'b1;
      end
`endif

      case (state_q)
         ST_IDLE, ST_ALLRED: begin
            // IDLE decides every cycle; ALLRED only on its final cycle
            if ((state_q == ST_IDLE) || (cnt_q == ALLRED_LAST)) begin
               state_d = ST_IDLE;
`ifdef JPS_PED_WALK_EN
               if (ped_pending_q) begin
                  state_d       = ST_WALK;
                  ped_pending_d = 1'b0;
               end else
`endif
               if (grant_any) begin
                  state_d  = ST_GREEN;
                  last_d   = grant_idx;
                  active_d = grant_idx;
               end
            end
         end
         ST_GREEN: begin
            if (cnt_q == GREEN_LAST) state_d = ST_YELLOW;
         end
         ST_YELLOW: begin
            if (cnt_q == YELLOW_LAST) state_d = ST_ALLRED;
         end
`ifdef JPS_PED_WALK_EN
         ST_WALK: begin
            if (cnt_q == WALK_LAST) state_d = ST_ALLRED;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Counter restarts on every state entry and is held at zero in IDLE
      if ((state_d != state_q) || (state_q == ST_IDLE)) begin
         cnt_d = '0;
      end

      // Outputs are derived from the next state so they register alongside it
      light_d = 8'h00;
      case (state_d)
         ST_GREEN:  light_d[{active_d, 1'b0} +: 2] = LIGHT_GREEN;
         ST_YELLOW: light_d[{active_d, 1'b0} +: 2] = LIGHT_YELLOW;
         default:   light_d = 8'h00;
      endcase
      idle_d = (state_d == ST_IDLE);
`ifdef JPS_PED_WALK_EN
      walk_d = (state_d == ST_WALK);
`endif
   end

   // State, counter, grant history and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         last_q   <= 2'd3;
         light_q  <= 8'h00;
         active_q <= 2'd0;
         idle_q   <= 1'b1;
`ifdef JPS_PED_WALK_EN
         ped_pending_q <= 1'b0;
         walk_q        <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         light_q  <= light_d;
         active_q <= active_d;
         idle_q   <= idle_d;
`ifdef JPS_PED_WALK_EN
         ped_pending_q <= ped_pending_d;
         walk_q        <= walk_d;
`endif
      end
   end

   assign light  = light_q;
   assign active = active_q;
   assign idle   = idle_q;
`ifdef JPS_PED_WALK_EN
   assign walk   = walk_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_junction_phase_scheduler.sv
// ============================================================================
//  Module      : tb_junction_phase_scheduler
//  Description : Directed self-checking bench for junction_phase_scheduler.
//                Pedestrian steps are compiled only with JPS_PED_WALK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_junction_phase_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [7:0] light;
   logic [1:0] active;
   logic       idle;
`ifdef JPS_PED_WALK_EN
   logic       ped_req;
   logic       walk;
`endif

   int checks   = 0;
   int failures = 0;

   junction_phase_scheduler dut (
      .clk    (clk),
      .rst    (rst),
`ifdef JPS_PED_WALK_EN
      .ped_req(ped_req),
      .walk   (walk),
`endif
      .req    (req),
      .light  (light),
      .active (active),
      .idle   (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] el,
                      input logic [1:0] ea, input logic ei);
      checks++;
      assert (light === el) else begin
         failures++;
         $error("FAIL %s light observed=%h expected=%h", tag, light, el);
      end
      checks++;
      assert (active === ea) else begin
         failures++;
         $error("FAIL %s active observed=%0d expected=%0d", tag, active, ea);
      end
      checks++;
      assert (idle === ei) else begin
         failures++;
         $error("FAIL %s idle observed=%b expected=%b", tag, idle, ei);
      end
   endtask

   // Check n consecutive cycles of one phase, advancing after each check
   task automatic run(input string tag, input int n, input logic [7:0] el,
                      input logic [1:0] ea, input logic ei);
      for (int i = 0; i < n; i++) begin
         chk(tag, el, ea, ei);
         tick();
      end
   endtask

`ifdef JPS_PED_WALK_EN
   task automatic chk_walk(input string tag, input logic ew);
      checks++;
      assert (walk === ew) else begin
         failures++;
         $error("FAIL %s walk observed=%b expected=%b", tag, walk, ew);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      req = 4'b0000;
`ifdef JPS_PED_WALK_EN
      ped_req = 1'b0;
`endif
      tick();
      chk("reset", 8'h00, 2'd0, 1'b1);
      rst = 1'b0;

      // Quiet junction stays idle
      run("quiet", 20, 8'h00, 2'd0, 1'b1);

      // Single pulse on approach 1: one full sequence then back to IDLE
      req = 4'b0010;
      tick();
      req = 4'b0000;
      run("p1_green", 10, 8'h04, 2'd1, 1'b0);
      run("p1_yellow", 5, 8'h08, 2'd1, 1'b0);
      run("p1_allred", 2, 8'h00, 2'd1, 1'b0);
      chk("p1_idle", 8'h00, 2'd1, 1'b1);

      // From reset, 0 and 2 alternate without returning to IDLE
      rst = 1'b1;
      tick();
      chk("reset2", 8'h00, 2'd0, 1'b1);
      rst = 1'b0;
      req = 4'b0101;
      tick();
      run("a0_green", 10, 8'h01, 2'd0, 1'b0);
      run("a0_yellow", 5, 8'h02, 2'd0, 1'b0);
      run("a0_allred", 2, 8'h00, 2'd0, 1'b0);
      // Requests moving mid-green are ignored until the final all-red cycle
      req = 4'b1000;
      run("a2_green", 5, 8'h10, 2'd2, 1'b0);
      req = 4'b0101;
      run("a2_green_b", 5, 8'h10, 2'd2, 1'b0);
      run("a2_yellow", 5, 8'h20, 2'd2, 1'b0);
      run("a2_allred", 2, 8'h00, 2'd2, 1'b0);
      run("b0_green", 10, 8'h01, 2'd0, 1'b0);
      run("b0_yellow", 5, 8'h02, 2'd0, 1'b0);
      run("b0_allred", 2, 8'h00, 2'd0, 1'b0);
      run("b2_green", 10, 8'h10, 2'd2, 1'b0);
      run("b2_yellow", 5, 8'h20, 2'd2, 1'b0);
      run("b2_allred", 2, 8'h00, 2'd2, 1'b0);

      // Reset in green cycle 4 aborts; next grant scans from 0 again
      run("c0_green", 3, 8'h01, 2'd0, 1'b0);
      chk("c0_green4", 8'h01, 2'd0, 1'b0);
      rst = 1'b1;
      tick();
      chk("abort", 8'h00, 2'd0, 1'b1);
      rst = 1'b0;
      req = 4'b1001;
      tick();
      run("d0_green", 10, 8'h01, 2'd0, 1'b0);
      run("d0_yellow", 5, 8'h02, 2'd0, 1'b0);
      run("d0_allred", 2, 8'h00, 2'd0, 1'b0);
      req = 4'b0000;
      run("d3_green", 10, 8'h40, 2'd3, 1'b0);
      run("d3_yellow", 5, 8'h80, 2'd3, 1'b0);
      run("d3_allred", 2, 8'h00, 2'd3, 1'b0);
      chk("d_idle", 8'h00, 2'd3, 1'b1);

`ifdef JPS_PED_WALK_EN
      // Pedestrian request during approach 3 green with all approaches busy
      rst = 1'b1;
      tick();
      chk_walk("walk_reset", 1'b0);
      rst = 1'b0;
      req = 4'b1000;
      tick();
      req = 4'b1111;
      run("e3_green", 4, 8'h40, 2'd3, 1'b0);
      ped_req = 1'b1;
      tick();
      ped_req = 1'b0;
      run("e3_green_b", 5, 8'h40, 2'd3, 1'b0);
      run("e3_yellow", 5, 8'h80, 2'd3, 1'b0);
      run("e3_allred", 2, 8'h00, 2'd3, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk("walk", 8'h00, 2'd3, 1'b0);
         chk_walk("walk", 1'b1);
         // A second pulse inside WALK must be dropped
         ped_req = (i == 3);
         tick();
      end
      ped_req = 1'b0;
      chk_walk("walk_end", 1'b0);
      run("w_allred", 2, 8'h00, 2'd3, 1'b0);
      run("f0_green", 10, 8'h01, 2'd0, 1'b0);
      run("f0_yellow", 5, 8'h02, 2'd0, 1'b0);
      run("f0_allred", 2, 8'h00, 2'd0, 1'b0);
      chk("f1_green", 8'h04, 2'd1, 1'b0);
      chk_walk("no_second_walk", 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
